wait_cycle_counter: RTL and testbench

- Parametrised, programmable successor to the 3-bit free-running counter used by the cache control path.
- Counts up or down from a loaded start value to a programmable terminal value, in one-shot or periodic mode.
- Supports clock enable and start/stop control, and raises a one-cycle End pulse at each terminal hit.
- Used by the cache controller to time miss-penalty and refill wait states.

---
 rtl/wait_cycle_counter.sv | 125 ++++++++++++
 tb/tb_wait_cycle_counter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/wait_cycle_counter.sv
// Programmable up/down wait-state counter with one-shot and periodic modes.
// Raises a single-cycle end pulse each time the captured terminal value is reached.
module wait_cycle_counter #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned INIT  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] term_val,
  output logic [WIDTH-1:0] out,
  output logic             End,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] INIT_VAL = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             end_q, end_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic             dir_q, dir_d;
  logic             mode_q, mode_d;
  logic             capture;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    end_d   = 1'b0;
    capture = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          capture = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (start) begin
          capture = 1'b1;
        end else if (en) begin
          if (out_q == term_q) begin
            end_d = 1'b1;
            if (mode_q) begin
              out_d = start_q;
            end else begin
              state_d = DONE;
            end
          end else if (dir_q) begin
            out_d = out_q - ONE;
          end else begin
            out_d = out_q + ONE;
          end
        end
      end
      DONE: begin
        if (stop) begin
          state_d = IDLE;
        end else if (start) begin
          capture = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A (re)start always wins over stepping and replaces every captured setting.
    if (capture) begin
      state_d = RUN;
      out_d   = load_val;
      start_d = load_val;
      term_d  = term_val;
      dir_d   = dir;
      mode_d  = mode;
    end else begin
      start_d = start_q;
      term_d  = term_q;
      dir_d   = dir_q;
      mode_d  = mode_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      out_q   <= INIT_VAL;
      end_q   <= 1'b0;
      start_q <= '0;
      term_q  <= '0;
      dir_q   <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      end_q   <= end_d;
      start_q <= start_d;
      term_q  <= term_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
    end
  end

  assign out  = out_q;
  assign End  = end_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_wait_cycle_counter.sv
// Directed vector bench for wait_cycle_counter (WIDTH=3, INIT=0).
// A vector table drives one clock edge per entry; async reset is checked by hand.
module tb_wait_cycle_counter;

  localparam int WIDTH = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             en = 1'b0;
  logic             dir = 1'b0;
  logic             mode = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic [WIDTH-1:0] term_val = '0;
  logic [WIDTH-1:0] out;
  logic             End;
  logic             busy;
  logic             done;

  int applied = 0;
  int miscompares = 0;

  wait_cycle_counter #(.WIDTH(WIDTH), .INIT(0)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .en       (en),
    .dir      (dir),
    .mode     (mode),
    .load_val (load_val),
    .term_val (term_val),
    .out      (out),
    .End      (End),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             start;
    logic             stop;
    logic             en;
    logic             dir;
    logic             mode;
    logic [WIDTH-1:0] load;
    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] exp_out;
    logic             exp_end;
    logic             exp_busy;
    logic             exp_done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic s, logic p, logic e, logic d, logic m,
                              logic [WIDTH-1:0] ld, logic [WIDTH-1:0] tm,
                              logic [WIDTH-1:0] eo, logic ee, logic eb, logic ed);
    vec_t v;
    v.start = s; v.stop = p; v.en = e; v.dir = d; v.mode = m;
    v.load = ld; v.term = tm;
    v.exp_out = eo; v.exp_end = ee; v.exp_busy = eb; v.exp_done = ed;
    return v;
  endfunction

  // Non-start edge: dir/mode/load/term carry junk so captured copies must be used.
  function automatic vec_t step(logic e, logic p, logic [WIDTH-1:0] eo,
                                logic ee, logic eb, logic ed);
    logic [WIDTH-1:0] junk_load;
    logic [WIDTH-1:0] junk_term;
    junk_load = ~eo;
    junk_term = eo + 3'd3;
    return mk(1'b0, p, e, eo[0], ~eo[1], junk_load, junk_term, eo, ee, eb, ed);
  endfunction

  task automatic check_output(string name, logic [WIDTH-1:0] e_out,
                              logic e_end, logic e_busy, logic e_done);
    applied++;
    if ({out, End, busy, done} !== {e_out, e_end, e_busy, e_done}) begin
      miscompares++;
      $display("[TB] FAIL %s: got out=%0d End=%0b busy=%0b done=%0b, want out=%0d End=%0b busy=%0b done=%0b",
               name, out, End, busy, done, e_out, e_end, e_busy, e_done);
    end
  endtask

  task automatic apply_stimulus(vec_t v);
    @(negedge clk);
    start    = v.start;
    stop     = v.stop;
    en       = v.en;
    dir      = v.dir;
    mode     = v.mode;
    load_val = v.load;
    term_val = v.term;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Up periodic 0..6: End on the 7th enabled edge, coincident with reload to 0.
    vecs.push_back(mk(1, 0, 1, 0, 1, 3'd0, 3'd6, 3'd0, 0, 1, 0));
    for (int i = 1; i <= 6; i++) vecs.push_back(step(1, 0, 3'(i), 0, 1, 0));
    vecs.push_back(step(1, 0, 3'd0, 1, 1, 0));
    vecs.push_back(step(1, 0, 3'd1, 0, 1, 0));
    vecs.push_back(step(1, 1, 3'd1, 0, 0, 0));
    vecs.push_back(step(1, 0, 3'd1, 0, 0, 0));
    // Down one-shot 2 -> 5 through the 0 -> 7 wrap.
    vecs.push_back(mk(1, 0, 1, 1, 0, 3'd2, 3'd5, 3'd2, 0, 1, 0));
    vecs.push_back(step(1, 0, 3'd1, 0, 1, 0));
    vecs.push_back(step(1, 0, 3'd0, 0, 1, 0));
    vecs.push_back(step(1, 0, 3'd7, 0, 1, 0));
    vecs.push_back(step(1, 0, 3'd6, 0, 1, 0));
    vecs.push_back(step(1, 0, 3'd5, 0, 1, 0));
    vecs.push_back(step(1, 0, 3'd5, 1, 0, 1));
    vecs.push_back(step(1, 0, 3'd5, 0, 0, 1));
    // Restart from DONE with load == term, one-shot.
    vecs.push_back(mk(1, 0, 1, 0, 0, 3'd1, 3'd1, 3'd1, 0, 1, 0));
    vecs.push_back(step(1, 0, 3'd1, 1, 0, 1));
    vecs.push_back(step(0, 1, 3'd1, 0, 0, 0));
    // Up periodic 3..6 with enable dropped for three edges at 4.
    vecs.push_back(mk(1, 0, 1, 0, 1, 3'd3, 3'd6, 3'd3, 0, 1, 0));
    vecs.push_back(step(1, 0, 3'd4, 0, 1, 0));
    vecs.push_back(step(0, 0, 3'd4, 0, 1, 0));
    vecs.push_back(step(0, 0, 3'd4, 0, 1, 0));
    vecs.push_back(step(0, 0, 3'd4, 0, 1, 0));
    vecs.push_back(step(1, 0, 3'd5, 0, 1, 0));
    vecs.push_back(step(1, 0, 3'd6, 0, 1, 0));
    vecs.push_back(step(1, 0, 3'd3, 1, 1, 0));
    vecs.push_back(step(1, 0, 3'd4, 0, 1, 0));
    // stop and start on the same edge: stop wins, out holds at 2.
    vecs.push_back(mk(1, 0, 1, 0, 1, 3'd0, 3'd7, 3'd0, 0, 1, 0));
    vecs.push_back(step(1, 0, 3'd1, 0, 1, 0));
    vecs.push_back(step(1, 0, 3'd2, 0, 1, 0));
    vecs.push_back(mk(1, 1, 1, 0, 1, 3'd5, 3'd5, 3'd2, 0, 0, 0));
    vecs.push_back(step(0, 1, 3'd2, 0, 0, 0));
    // Restart during RUN at 5 with load 0 / term 2: End after 3 enabled edges.
    vecs.push_back(mk(1, 0, 1, 0, 0, 3'd3, 3'd7, 3'd3, 0, 1, 0));
    vecs.push_back(step(1, 0, 3'd4, 0, 1, 0));
    vecs.push_back(step(1, 0, 3'd5, 0, 1, 0));
    vecs.push_back(mk(1, 0, 1, 0, 1, 3'd0, 3'd2, 3'd0, 0, 1, 0));
    vecs.push_back(step(1, 0, 3'd1, 0, 1, 0));
    vecs.push_back(step(1, 0, 3'd2, 0, 1, 0));
    vecs.push_back(step(1, 0, 3'd0, 1, 1, 0));
    // Up one-shot 6 -> 1 through the 7 -> 0 wrap.
    vecs.push_back(mk(1, 0, 1, 0, 0, 3'd6, 3'd1, 3'd6, 0, 1, 0));
    vecs.push_back(step(1, 0, 3'd7, 0, 1, 0));
    vecs.push_back(step(1, 0, 3'd0, 0, 1, 0));
    vecs.push_back(step(1, 0, 3'd1, 0, 1, 0));
    vecs.push_back(step(1, 0, 3'd1, 1, 0, 1));
    // Periodic with load == term pulses End on every enabled edge.
    vecs.push_back(mk(1, 0, 1, 0, 1, 3'd4, 3'd4, 3'd4, 0, 1, 0));
    vecs.push_back(step(1, 0, 3'd4, 1, 1, 0));
    vecs.push_back(step(1, 0, 3'd4, 1, 1, 0));
    vecs.push_back(step(0, 0, 3'd4, 0, 1, 0));

    #1;
    check_output("reset_state", 3'd0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i]);
      check_output($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_end,
                   vecs[i].exp_busy, vecs[i].exp_done);
    end

    // Asynchronous reset mid-RUN at out=4, checked before the next posedge.
    apply_stimulus(mk(1, 0, 1, 0, 1, 3'd0, 3'd7, 3'd0, 0, 1, 0));
    for (int i = 1; i <= 4; i++) apply_stimulus(step(1, 0, 3'(i), 0, 1, 0));
    check_output("pre_reset_out4", 3'd4, 0, 1, 0);
    #1;
    reset = 1'b0;
    #1;
    check_output("async_reset_midrun", 3'd0, 0, 0, 0);
    apply_stimulus(mk(1, 0, 1, 0, 1, 3'd5, 3'd5, 3'd0, 0, 0, 0));
    check_output("reset_held_ignores_start", 3'd0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    check_output("after_reset_release_idle", 3'd0, 0, 0, 0);

    // Reset with an End pending: the pulse must never appear.
    apply_stimulus(mk(1, 0, 1, 0, 1, 3'd2, 3'd2, 3'd2, 0, 1, 0));
    check_output("pending_end_setup", 3'd2, 0, 1, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_output("reset_kills_pending_end", 3'd0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
